int_arbiter: RTL and testbench

- Interrupt controller in front of the PC-redirect/EPC unit.
- Collects NUM_SRC interrupt lines, edge-detects them into a pending register, applies a software-written enable mask, and picks one source by fixed priority.
- Issues a single held interrupt request with the source ID and handler vector, then blocks further requests until the handler executes eret.
- No nesting; one interrupt in service at a time.

---
 rtl/int_arbiter.sv | 129 ++++++++++++
 tb/tb_int_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_arbiter.sv
// Interrupt arbiter: edge-detects sources into a pending register, masks them,
// and issues one fixed-priority request at a time, held off until eret.
module int_arbiter #(
    parameter int                   NUM_SRC  = 4,
    parameter int                   ID_W     = 2,
    parameter logic [31:0]          VEC_BASE = 32'h0000_0004,
    parameter logic [NUM_SRC-1:0]   MASK_RST = '1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               int_ack,
    input  logic               eret,
    output logic               int_req,
    output logic [ID_W-1:0]    int_id,
    output logic [31:0]        vector,
    output logic               busy,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] mask
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state_q;
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] mask_q;
    logic               req_q;
    logic               busy_q;
    logic [ID_W-1:0]    id_q;
    logic [31:0]        vec_q;

    logic [NUM_SRC-1:0] edges;
    logic [NUM_SRC-1:0] eligible;
    logic [ID_W-1:0]    win;
    logic               ack_clr;

    assign edges    = irq_in & ~prev_q;
    assign eligible = pend_q & mask_q;
    assign ack_clr  = (state_q == REQ) && int_ack;

    // Lowest set index of the eligible vector wins.
    always_comb begin
        win = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win = ID_W'(i);
            end
        end
    end

    // Acknowledge clears the in-service bit; a same-cycle edge sets it again.
    always_comb begin
        pend_d = pend_q;
        if (ack_clr) begin
            pend_d[id_q] = 1'b0;
        end
        pend_d = pend_d | edges;
    end

    // Edge history, pending bits and the software mask.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
            pend_q <= '0;
            mask_q <= MASK_RST;
        end else begin
            prev_q <= irq_in;
            pend_q <= pend_d;
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
        end
    end

    // Request/service sequencing with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            id_q    <= '0;
            vec_q   <= VEC_BASE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|eligible) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        id_q    <= win;
                        vec_q   <= VEC_BASE + (32'(win) << 2);
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        state_q <= SERVICE;
                        req_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                SERVICE: begin
                    if (eret) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign int_req = req_q;
    assign busy    = busy_q;
    assign int_id  = id_q;
    assign vector  = vec_q;
    assign pending = pend_q;
    assign mask    = mask_q;

endmodule

// File: tb/tb_int_arbiter.sv
// Bench for int_arbiter: directed scenarios with literal expectations
// plus random traffic checked every cycle against a behavioural model.
module tb_int_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq_in;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic        int_ack;
    logic        eret;
    logic        int_req;
    logic [1:0]  int_id;
    logic [31:0] vector;
    logic        busy;
    logic [3:0]  pending;
    logic [3:0]  mask;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Model: phase 0 = idle, 1 = requesting, 2 = in service.
    bit m_pend[4];
    bit m_mask[4];
    bit m_prev[4];
    int m_phase;
    int m_id;

    int_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .mask_we   (mask_we),
        .mask_wdata(mask_wdata),
        .int_ack   (int_ack),
        .eret      (eret),
        .int_req   (int_req),
        .int_id    (int_id),
        .vector    (vector),
        .busy      (busy),
        .pending   (pending),
        .mask      (mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] pack(input bit a[4]);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = a[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 1'b0;
            m_mask[i] = 1'b1;
            m_prev[i] = 1'b0;
        end
        m_phase = 0;
        m_id    = 0;
    endtask

    // One clock edge of the spec rules, using the inputs present at the edge.
    task automatic model_step();
        bit np[4];
        int w;
        for (int i = 0; i < 4; i++) np[i] = m_pend[i];
        case (m_phase)
            0: begin
                w = -1;
                for (int i = 3; i >= 0; i--)
                    if (m_pend[i] && m_mask[i]) w = i;
                if (w >= 0) begin
                    m_phase = 1;
                    m_id    = w;
                end
            end
            1: if (int_ack) begin
                m_phase   = 2;
                np[m_id] = 1'b0;
            end
            default: if (eret) m_phase = 0;
        endcase
        for (int i = 0; i < 4; i++) begin
            if (irq_in[i] && !m_prev[i]) np[i] = 1'b1;
            m_prev[i] = irq_in[i];
            if (mask_we) m_mask[i] = mask_wdata[i];
            m_pend[i] = np[i];
        end
    endtask

    // Advance one cycle; returns just after the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    // Compare all outputs to the model on every falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("int_req", 32'(int_req), 32'(m_phase == 1));
            chk("busy", 32'(busy), 32'(m_phase == 2));
            chk("int_id", 32'(int_id), 32'(m_id));
            chk("vector", vector, 32'h4 + 32'(m_id) * 4);
            chk("pending", 32'(pending), 32'(pack(m_pend)));
            chk("mask", 32'(mask), 32'(pack(m_mask)));
        end
    end

    int nreq;

    initial begin
        reset      = 1'b1;
        irq_in     = '0;
        mask_we    = 1'b0;
        mask_wdata = '0;
        int_ack    = 1'b0;
        eret       = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check_en = 1'b1;
        chk("rst_req", 32'(int_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pend", 32'(pending), 0);
        chk("rst_mask", 32'(mask), 32'hF);
        chk("rst_vec", vector, 32'h4);

        // Single source, full request/ack handshake.
        irq_in = 4'b0100;
        tick();
        chk("t1_pend", 32'(pending), 32'h4);
        chk("t1_req0", 32'(int_req), 0);
        tick();
        chk("t1_req", 32'(int_req), 1);
        chk("t1_id", 32'(int_id), 2);
        chk("t1_vec", vector, 32'hC);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("t1_busy", 32'(busy), 1);
        chk("t1_pend0", 32'(pending), 0);
        chk("t1_req_lo", 32'(int_req), 0);
        eret   = 1'b1;
        irq_in = '0;
        tick();
        eret = 1'b0;

        // Two simultaneous sources: priority then back-to-back after eret.
        irq_in = 4'b1010;
        tick();
        tick();
        chk("t2_id", 32'(int_id), 1);
        chk("t2_vec", vector, 32'h8);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        eret    = 1'b1;
        tick();
        eret = 1'b0;
        chk("t2_idle", 32'(int_req), 0);
        tick();
        chk("t2_req", 32'(int_req), 1);
        chk("t2_id3", 32'(int_id), 3);
        chk("t2_vec3", vector, 32'h10);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        eret    = 1'b1;
        tick();
        eret   = 1'b0;
        irq_in = '0;

        // Masked source held pending, released by mask write.
        mask_we    = 1'b1;
        mask_wdata = 4'b1110;
        irq_in     = 4'b0001;
        tick();
        mask_we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3_noreq", 32'(int_req), 0);
            chk("t3_pend0", 32'(pending[0]), 1);
        end
        mask_we    = 1'b1;
        mask_wdata = 4'b1111;
        tick();
        mask_we = 1'b0;
        tick();
        chk("t3_req", 32'(int_req), 1);
        chk("t3_id", 32'(int_id), 0);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;

        // New event while in service waits for eret; stray strobes ignored.
        irq_in = '0;
        tick();
        irq_in = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_noreq", 32'(int_req), 0);
            chk("t4_pend0", 32'(pending[0]), 1);
        end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("t4_busy", 32'(busy), 1);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        tick();
        chk("t4_req", 32'(int_req), 1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        eret    = 1'b1;
        tick();
        tick();
        chk("t4_eret_idle", 32'(busy), 0);
        eret    = 1'b0;
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("t4_ack_idle", 32'(int_req), 0);

        // Held level yields one request.
        irq_in = 4'b0010;
        nreq   = 0;
        for (int i = 0; i < 20; i++) begin
            int_ack = (m_phase == 1);
            eret    = (m_phase == 2);
            tick();
            if (int_req) nreq++;
        end
        int_ack = 1'b0;
        eret    = 1'b0;
        chk("t5_one_req", 32'(nreq), 1);

        // Asynchronous reset in the middle of a request.
        irq_in     = '0;
        mask_we    = 1'b1;
        mask_wdata = 4'b0111;
        tick();
        mask_we = 1'b0;
        irq_in  = 4'b0100;
        tick();
        tick();
        chk("t5_inreq", 32'(int_req), 1);
        check_en = 1'b0;
        irq_in   = '0;
        #2;
        reset = 1'b1;
        #1;
        chk("ar_req", 32'(int_req), 0);
        chk("ar_pend", 32'(pending), 0);
        chk("ar_mask", 32'(mask), 32'hF);
        chk("ar_vec", vector, 32'h4);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_en = 1'b1;

        // Clear and new edge on the same bit in the same cycle.
        irq_in = 4'b0100;
        tick();
        tick();
        irq_in = '0;
        tick();
        chk("t6_req", 32'(int_req), 1);
        irq_in  = 4'b0100;
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("t6_busy", 32'(busy), 1);
        chk("t6_pend2", 32'(pending[2]), 1);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        tick();
        chk("t6_rereq", 32'(int_req), 1);
        chk("t6_id", 32'(int_id), 2);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            irq_in     = 4'($urandom);
            mask_we    = ($urandom % 8) == 0;
            mask_wdata = 4'($urandom);
            int_ack    = (m_phase == 1) ? (($urandom % 3) == 0)
                                        : (($urandom % 10) == 0);
            eret       = (m_phase == 2) ? (($urandom % 4) == 0)
                                        : (($urandom % 10) == 0);
            tick();
        end

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
